// File: rtl/down_counter_timer.sv
// Two-digit BCD down-counter timer with start/pause control, optional auto-reload
// and a one-cycle terminal-count pulse. All outputs are registered.
module down_counter_timer #(
  parameter logic [3:0] PRESET_TENS = 4'd5,
  parameter logic [3:0] PRESET_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  input  logic       reload_en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       tc_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] rld_tens_q, rld_tens_d;
  logic [3:0] rld_ones_q, rld_ones_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tc_q, tc_d;

  logic       cnt_zero;
  logic       cnt_last;
  logic       rld_zero;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    clamp_bcd = (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Single BCD decrement; callers guarantee the count is above 01.
  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd0) bcd_dec = {t, o - 4'd1};
    else           bcd_dec = {t - 4'd1, 4'd9};
  endfunction

  assign cnt_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign cnt_last = (tens_q == 4'd0) && (ones_q <= 4'd1);
  assign rld_zero = (rld_tens_q == 4'd0) && (rld_ones_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    rld_tens_d = rld_tens_q;
    rld_ones_d = rld_ones_q;
    tc_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          tens_d     = clamp_bcd(load_tens);
          ones_d     = clamp_bcd(load_ones);
          rld_tens_d = clamp_bcd(load_tens);
          rld_ones_d = clamp_bcd(load_ones);
        end else if (start) begin
          if (cnt_zero) begin
            state_d = DONE;
            tc_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // load has no effect while running, so it does not mask pause or en.
        if (pause) begin
          state_d = PAUSE;
        end else if (en) begin
          if (cnt_last) begin
            tc_d = 1'b1;
            if (reload_en && !rld_zero) begin
              tens_d = rld_tens_q;
              ones_d = rld_ones_q;
            end else begin
              tens_d  = 4'd0;
              ones_d  = 4'd0;
              state_d = DONE;
            end
          end else begin
            {tens_d, ones_d} = bcd_dec(tens_q, ones_q);
          end
        end
      end

      PAUSE: begin
        if (load) begin
          tens_d     = clamp_bcd(load_tens);
          ones_d     = clamp_bcd(load_ones);
          rld_tens_d = clamp_bcd(load_tens);
          rld_ones_d = clamp_bcd(load_ones);
          state_d    = IDLE;
        end else if (!pause && start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (load) begin
          tens_d     = clamp_bcd(load_tens);
          ones_d     = clamp_bcd(load_ones);
          rld_tens_d = clamp_bcd(load_tens);
          rld_ones_d = clamp_bcd(load_ones);
          state_d    = IDLE;
        end else if (start) begin
          tens_d = rld_tens_q;
          ones_d = rld_ones_q;
          if (rld_zero) tc_d = 1'b1;
          else          state_d = RUN;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tens_q     <= PRESET_TENS;
      ones_q     <= PRESET_ONES;
      rld_tens_q <= PRESET_TENS;
      rld_ones_q <= PRESET_ONES;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      rld_tens_q <= rld_tens_d;
      rld_ones_q <= rld_ones_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tc_q       <= tc_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: each driven cycle queues the expected
// registered outputs, and a monitor compares them one clock later.
module tb_down_counter_timer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic       reload_en;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  logic       tc_pulse;

  down_counter_timer #(
    .PRESET_TENS(4'd5),
    .PRESET_ONES(4'd9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .start     (start),
    .pause     (pause),
    .reload_en (reload_en),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .tc_pulse  (tc_pulse)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       tc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;
  int    errors;
  int    checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_t = tag_q.pop_front();
      check({mon_t, ".cnt"},  {tens, ones},       mon_e.cnt);
      check({mon_t, ".busy"}, {7'd0, busy},       {7'd0, mon_e.busy});
      check({mon_t, ".done"}, {7'd0, done},       {7'd0, mon_e.done});
      check({mon_t, ".tc"},   {7'd0, tc_pulse},   {7'd0, mon_e.tc});
    end
  end

  // Queue expectation for the next edge, wait for it, then clear the strobes.
  task automatic cyc(input string tag, input logic [7:0] cnt, input logic b,
                     input logic d, input logic t);
    exp_t x;
    x.cnt  = cnt;
    x.busy = b;
    x.done = d;
    x.tc   = t;
    sb_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    en    = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [3:0] t, input logic [3:0] o,
                         input logic [7:0] cnt);
    load      = 1'b1;
    load_tens = t;
    load_ones = o;
    cyc(tag, cnt, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    load_tens = 4'd0;
    load_ones = 4'd0;
    start     = 1'b0;
    pause     = 1'b0;
    reload_en = 1'b0;

    cyc("reset", 8'h59, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      cyc("idle_en", 8'h59, 1'b0, 1'b0, 1'b0);
    end

    do_load("load12", 4'd1, 4'd2, 8'h12);
    start = 1'b1;
    cyc("start12", 8'h12, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      v  = 12 - i;
      en = 1'b1;
      cyc("run12", {4'(v / 10), 4'(v % 10)}, v != 0, v == 0, v == 0);
    end
    cyc("done_hold", 8'h00, 1'b0, 1'b1, 1'b0);

    do_load("load10", 4'd1, 4'd0, 8'h10);
    start = 1'b1;
    cyc("start10", 8'h10, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("borrow", 8'h09, 1'b1, 1'b0, 1'b0);

    pause = 1'b1;
    cyc("pause09", 8'h09, 1'b1, 1'b0, 1'b0);
    do_load("load03", 4'd0, 4'd3, 8'h03);
    start = 1'b1;
    cyc("start03", 8'h03, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("dec02", 8'h02, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    start = 1'b1;
    cyc("pause_win", 8'h02, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      cyc("paused_en", 8'h02, 1'b1, 1'b0, 1'b0);
    end
    start = 1'b1;
    cyc("resume", 8'h02, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("dec01", 8'h01, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("dec00", 8'h00, 1'b0, 1'b1, 1'b1);
    cyc("tc_drop", 8'h00, 1'b0, 1'b1, 1'b0);

    do_load("load02", 4'd0, 4'd2, 8'h02);
    reload_en = 1'b1;
    start = 1'b1;
    cyc("start02", 8'h02, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      en = 1'b1;
      if (i % 2 == 0) cyc("rld_dec", 8'h01, 1'b1, 1'b0, 1'b0);
      else            cyc("rld_tc",  8'h02, 1'b1, 1'b0, 1'b1);
    end
    reload_en = 1'b0;
    pause = 1'b1;
    cyc("rld_pause", 8'h02, 1'b1, 1'b0, 1'b0);

    do_load("load01", 4'd0, 4'd1, 8'h01);
    start = 1'b1;
    cyc("start01", 8'h01, 1'b1, 1'b0, 1'b0);
    reload_en = 1'b1;
    en = 1'b1;
    cyc("rld01_a", 8'h01, 1'b1, 1'b0, 1'b1);
    en = 1'b1;
    cyc("rld01_b", 8'h01, 1'b1, 1'b0, 1'b1);
    reload_en = 1'b0;
    en = 1'b1;
    cyc("end01", 8'h00, 1'b0, 1'b1, 1'b1);
    start = 1'b1;
    cyc("done_restart", 8'h01, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("restart_end", 8'h00, 1'b0, 1'b1, 1'b1);

    do_load("load00", 4'd0, 4'd0, 8'h00);
    start = 1'b1;
    cyc("start00", 8'h00, 1'b0, 1'b1, 1'b1);
    cyc("hold00", 8'h00, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    cyc("redone00", 8'h00, 1'b0, 1'b1, 1'b1);

    do_load("clamp", 4'hF, 4'hC, 8'h99);
    start = 1'b1;
    cyc("start99", 8'h99, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("dec98", 8'h98, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("dec97", 8'h97, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("dec96", 8'h96, 1'b1, 1'b0, 1'b0);
    load      = 1'b1;
    load_tens = 4'd0;
    load_ones = 4'd5;
    cyc("run_load_ign", 8'h96, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rst_run", 8'h59, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    cyc("post_rst_idle", 8'h59, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    cyc("start59", 8'h59, 1'b1, 1'b0, 1'b0);
    rst   = 1'b1;
    en    = 1'b1;
    load  = 1'b1;
    pause = 1'b1;
    cyc("rst_prio", 8'h59, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 The module SHALL take parameter PRESET_TENS, default 4'd5: the tens digit loaded at reset.
REQ-002 The module SHALL take parameter PRESET_ONES, default 4'd9: the ones digit loaded at reset.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  count tick, one-cycle strobe (e.g. 1 Hz enable); effective only in RUN.
REQ-007 load  input  1  load load_tens/load_ones into count and reload register.
REQ-008 load_tens  input  4  BCD tens value to load.
REQ-009 load_ones  input  4  BCD ones value to load.
REQ-010 start  input  1  start/resume strobe.
REQ-011 pause  input  1  pause strobe.
REQ-012 reload_en  input  1  level; 1 = auto-reload and keep running at terminal count.
REQ-013 tens  output  4  current tens digit (BCD, registered).
REQ-014 ones  output  4  current ones digit (BCD, registered).
REQ-015 busy  output  1  high in RUN or PAUSE.
REQ-016 done  output  1  high in DONE.
REQ-017 tc_pulse  output  1  one-cycle pulse on reaching 00.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE. All outputs SHALL be registered and change one clock after the qualifying input edge.
REQ-019 Same-cycle input priority SHALL be rst > load > pause > start > en.
REQ-020 load in IDLE, PAUSE or DONE SHALL write the count and reload register and enter IDLE. Any digit >9 SHALL be clamped to 9. load in RUN SHALL be ignored.
REQ-021 start in IDLE SHALL enter RUN if the count is nonzero. If the count is 00, it SHALL enter DONE and pulse tc_pulse.
REQ-022 In RUN, en=1 SHALL decrement the count in BCD: if ones>0, ones-1; else ones=9 and tens-1.
REQ-023 In RUN, en=1 with a count of 01 SHALL set the count to 00, pulse tc_pulse, and enter DONE if reload_en=0. If reload_en=1, it SHALL load the reload register in the same cycle, stay in RUN, and still pulse tc_pulse.
REQ-024 pause in RUN SHALL enter PAUSE and freeze the count. If pause and start arrive together, pause SHALL win.
REQ-025 start in PAUSE SHALL return to RUN without changing the count. en in IDLE, PAUSE or DONE SHALL be ignored.
REQ-026 start in DONE SHALL copy the reload register to the count and enter RUN. If the reload value is 00, it SHALL re-enter DONE and pulse tc_pulse.
REQ-027 The count SHALL never go below 00 and never hold a non-BCD digit.
REQ-028 tc_pulse SHALL be high for exactly one cycle per terminal event and SHALL never be high on consecutive cycles unless the reload value is 01 with en held high.

Reset
REQ-029 On a rising clk with rst=1: state=IDLE, tens=PRESET_TENS, ones=PRESET_ONES, reload register=preset, busy=0, done=0, tc_pulse=0.
REQ-030 rst in any state, including mid-RUN with en=1, SHALL override all other inputs in that cycle.

Verification
REQ-031 Apply rst, then hold en=1 with no start for 5 cycles -> count stays 59, busy=0.
REQ-032 Load 12, start, then 12 en pulses -> count follows 11,10,09 ... 00; tc_pulse once on the cycle after the 12th en; done=1; busy=0.
REQ-033 Load 10, start, then 1 en -> count=09 (ones wrap with tens borrow).
REQ-034 Load 03, start, en, pause+start in the same cycle, then 4 en -> state=PAUSE, count=02. Then start, 2 en -> count=00, done=1.
REQ-035 Load 02, reload_en=1, start, 6 en -> count 01,02,01,02,01,02; tc_pulse 3 times; busy stays 1.
REQ-036 Load digits 0xF/0xC -> count=99. Then start, 3 en, assert load=1 with value 05 -> load ignored, count=96. Then rst -> count=59, IDLE.
